// File: rtl/fsquare.sv
// Pipelined single-precision squarer, y = x*x, for the FPU datapath.
// Four register ranks: classify, multiply, normalize/round, range-check/output.
module fsquare #(
  parameter int ROUND = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        x_valid,
  output logic [31:0] y,
  output logic        y_valid,
  output logic        ovf,
  output logic        unf
);

  localparam int DATA_W = 32;
  localparam int MANT_W = 24;
  localparam int PROD_W = 2 * MANT_W;
  localparam int TOP_W  = PROD_W - 22;
  localparam int EXP_W  = 10;

  localparam logic [DATA_W-1:0] POS_INF = 32'h7F80_0000;
  localparam logic [DATA_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [DATA_W-1:0] POS_ZERO = 32'h0000_0000;

  // Adds the guard bit to the mantissa; bit 23 of the result is the carry out.
  function automatic logic [MANT_W-1:0] round_mant(input logic [22:0] m, input logic g);
    logic [MANT_W-1:0] r;
    if (ROUND != 0) r = {1'b0, m} + {{(MANT_W-1){1'b0}}, g};
    else            r = {1'b0, m};
    return r;
  endfunction

  // Returns {ovf, unf, y}; special operands win over the exponent range check.
  function automatic logic [DATA_W+1:0] pack_result(input logic signed [EXP_W-1:0] es,
                                                    input logic [22:0] m,
                                                    input logic zero, input logic inf,
                                                    input logic nan);
    logic [DATA_W+1:0] r;
    if (zero)                    r = {2'b00, POS_ZERO};
    else if (nan)                r = {2'b00, QNAN};
    else if (inf)                r = {2'b00, POS_INF};
    else if (es >= 10'sd255)     r = {2'b10, POS_INF};
    else if (es <= 10'sd0)       r = {2'b01, POS_ZERO};
    else                         r = {2'b00, 1'b0, es[7:0], m};
    return r;
  endfunction

  // The sign of x cannot affect x*x.
  logic unused_sign;
  assign unused_sign = x[31];

  logic                     vld_p0_d, vld_p0_q;
  logic [7:0]               exp_p0_d, exp_p0_q;
  logic [22:0]              frac_p0_d, frac_p0_q;
  logic                     zero_p0_d, zero_p0_q, inf_p0_d, inf_p0_q, nan_p0_d, nan_p0_q;

  logic                     vld_p1_d, vld_p1_q;
  logic [TOP_W-1:0]         prod_p1_d, prod_p1_q;
  logic signed [EXP_W-1:0]  es_p1_d, es_p1_q;
  logic                     zero_p1_d, zero_p1_q, inf_p1_d, inf_p1_q, nan_p1_d, nan_p1_q;
  logic [PROD_W-1:0]        mant_ext;

  logic                     vld_p2_d, vld_p2_q;
  logic [22:0]              mant_p2_d, mant_p2_q;
  logic signed [EXP_W-1:0]  es_p2_d, es_p2_q;
  logic                     zero_p2_d, zero_p2_q, inf_p2_d, inf_p2_q, nan_p2_d, nan_p2_q;
  logic [22:0]              mant_n;
  logic                     guard_n;
  logic signed [EXP_W-1:0]  es_n;
  logic [MANT_W-1:0]        rnd;

  logic                     y_valid_d, y_valid_q;
  logic [DATA_W-1:0]        y_d, y_q;
  logic                     ovf_d, ovf_q, unf_d, unf_q;
  logic [DATA_W+1:0]        res;

  // S1: split fields and classify the operand.
  always_comb begin
    vld_p0_d  = x_valid;
    exp_p0_d  = x[30:23];
    frac_p0_d = x[22:0];
    zero_p0_d = (x[30:23] == 8'h00);
    inf_p0_d  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    nan_p0_d  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  end

  // S2: square the significand, keeping only p[47:22]; es = 2e - 127.
  always_comb begin
    mant_ext  = {{(PROD_W-MANT_W){1'b0}}, 1'b1, frac_p0_q};
    prod_p1_d = TOP_W'((mant_ext * mant_ext) >> 22);
    es_p1_d   = $signed({1'b0, exp_p0_q, 1'b0}) - 10'sd127;
    vld_p1_d  = vld_p0_q;
    zero_p1_d = zero_p0_q;
    inf_p1_d  = inf_p0_q;
    nan_p1_d  = nan_p0_q;
  end

  // S3a: normalize on p[47] and round; prod_p1_q[25] is p[47].
  always_comb begin
    if (prod_p1_q[TOP_W-1]) begin
      mant_n  = prod_p1_q[24:2];
      guard_n = prod_p1_q[1];
      es_n    = es_p1_q + 10'sd1;
    end else begin
      mant_n  = prod_p1_q[23:1];
      guard_n = prod_p1_q[0];
      es_n    = es_p1_q;
    end
    rnd       = round_mant(mant_n, guard_n);
    mant_p2_d = rnd[22:0];
    es_p2_d   = es_n + (rnd[MANT_W-1] ? 10'sd1 : 10'sd0);
    vld_p2_d  = vld_p1_q;
    zero_p2_d = zero_p1_q;
    inf_p2_d  = inf_p1_q;
    nan_p2_d  = nan_p1_q;
  end

  // S3b: range check; outputs hold their last result between valid pulses.
  always_comb begin
    res       = pack_result(es_p2_q, mant_p2_q, zero_p2_q, inf_p2_q, nan_p2_q);
    y_valid_d = vld_p2_q;
    y_d       = y_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (vld_p2_q) begin
      y_d   = res[DATA_W-1:0];
      ovf_d = res[DATA_W+1];
      unf_d = res[DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    exp_p0_q  <= exp_p0_d;
    frac_p0_q <= frac_p0_d;
    zero_p0_q <= zero_p0_d;
    inf_p0_q  <= inf_p0_d;
    nan_p0_q  <= nan_p0_d;
    prod_p1_q <= prod_p1_d;
    es_p1_q   <= es_p1_d;
    zero_p1_q <= zero_p1_d;
    inf_p1_q  <= inf_p1_d;
    nan_p1_q  <= nan_p1_d;
    mant_p2_q <= mant_p2_d;
    es_p2_q   <= es_p2_d;
    zero_p2_q <= zero_p2_d;
    inf_p2_q  <= inf_p2_d;
    nan_p2_q  <= nan_p2_d;
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_fsquare.sv
// Directed bench for fsquare: a ROUND=1 and a ROUND=0 instance share the stimulus,
// a scoreboard holds hand-computed results with their due cycle.
module tb_fsquare;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] x;
  logic        x_valid;
  logic [31:0] y, yt;
  logic        y_valid, yt_valid, ovf, ovf_t, unf, unf_t;

  always #5 clk = ~clk;

  fsquare #(.ROUND(1)) dut (
    .clk(clk), .rstn(rstn), .x(x), .x_valid(x_valid),
    .y(y), .y_valid(y_valid), .ovf(ovf), .unf(unf)
  );

  fsquare #(.ROUND(0)) dut_trunc (
    .clk(clk), .rstn(rstn), .x(x), .x_valid(x_valid),
    .y(yt), .y_valid(yt_valid), .ovf(ovf_t), .unf(unf_t)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] yt;
    logic        ovf;
    logic        unf;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic [31:0] yt;
    logic        ovf;
    logic        unf;
    int          due;
  } exp_t;

  vec_t        vq[$];
  exp_t        sb[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_y, last_yt;
  logic        last_ovf, last_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic add_vec(input logic [31:0] xv, input logic [31:0] yv, input logic [31:0] ytv,
                         input logic o, input logic u);
    vq.push_back('{x: xv, y: yv, yt: ytv, ovf: o, unf: u});
  endtask

  task automatic drive(input logic v, input logic [31:0] xv, input vec_t ev, input bit track);
    @(negedge clk);
    x       = xv;
    x_valid = v;
    if (v && track) sb.push_back('{y: ev.y, yt: ev.yt, ovf: ev.ovf, unf: ev.unf, due: cyc + 4});
  endtask

  task automatic send(input int i);
    drive(1'b1, vq[i].x, vq[i], 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, 32'hDEAD_BEEF, vq[0], 1'b0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("overdue", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (y_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(y_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("latency", 32'(cyc), 32'(e.due));
          check("y", y, e.y);
          check("ovf", 32'(ovf), 32'(e.ovf));
          check("unf", 32'(unf), 32'(e.unf));
          check("trunc_valid", 32'(yt_valid), 32'd1);
          check("trunc_y", yt, e.yt);
          check("trunc_ovf", 32'(ovf_t), 32'(e.ovf));
          check("trunc_unf", 32'(unf_t), 32'(e.unf));
          last_y   = e.y;
          last_yt  = e.yt;
          last_ovf = e.ovf;
          last_unf = e.unf;
        end
      end else begin
        check("hold_y", y, last_y);
        check("hold_ovf", 32'(ovf), 32'(last_ovf));
        check("hold_unf", 32'(unf), 32'(last_unf));
        check("hold_trunc_y", yt, last_yt);
        check("trunc_idle", 32'(yt_valid), 32'd0);
      end
    end
  end

  initial begin
    rstn    = 1'b0;
    x       = 32'h0;
    x_valid = 1'b0;

    add_vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0); //  0: 1.0
    add_vec(32'h4040_0000, 32'h4110_0000, 32'h4110_0000, 1'b0, 1'b0); //  1: 3.0
    add_vec(32'h3FC0_0000, 32'h4010_0000, 32'h4010_0000, 1'b0, 1'b0); //  2: 1.5
    add_vec(32'hC000_0000, 32'h4080_0000, 32'h4080_0000, 1'b0, 1'b0); //  3: -2.0
    add_vec(32'h3F80_0001, 32'h3F80_0002, 32'h3F80_0002, 1'b0, 1'b0); //  4
    add_vec(32'h5F7F_FFFF, 32'h7F7F_FFFE, 32'h7F7F_FFFE, 1'b0, 1'b0); //  5: largest finite
    add_vec(32'h5F80_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b0); //  6: 2^64
    add_vec(32'h60AD_78EC, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b0); //  7
    add_vec(32'h1E3C_E508, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1); //  8: ~1e-20
    add_vec(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0); //  9: zero
    add_vec(32'h0040_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0); // 10: denormal
    add_vec(32'hFF80_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0); // 11: -inf
    add_vec(32'h7FA0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0, 1'b0); // 12: sNaN
    add_vec(32'h3F80_0800, 32'h3F80_1001, 32'h3F80_1000, 1'b0, 1'b0); // 13: guard=1
    add_vec(32'h2000_0000, 32'h0080_0000, 32'h0080_0000, 1'b0, 1'b0); // 14: smallest normal
    add_vec(32'h1FB5_04F4, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1); // 15: es=0 after norm
    add_vec(32'h3FB5_04F4, 32'h4000_0001, 32'h4000_0001, 1'b0, 1'b0); // 16: ~sqrt(2)
    add_vec(32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0); // 17: -1.0

    repeat (3) @(negedge clk);
    check("rst_y", y, 32'h0);
    check("rst_valid", 32'(y_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_unf", 32'(unf), 32'd0);
    check("rst_trunc_y", yt, 32'h0);
    last_y   = 32'h0;
    last_yt  = 32'h0;
    last_ovf = 1'b0;
    last_unf = 1'b0;
    mon_en   = 1'b1;
    rstn     = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      send(i);
      repeat (5) idle();
    end

    for (int i = 0; i < 10; i++) send(i);
    send(10);
    idle();
    send(11);
    send(12);
    idle();

    for (int i = 13; i < 18; i++) begin
      send(i);
      idle();
    end
    repeat (6) idle();

    drive(1'b1, vq[5].x, vq[5], 1'b0);
    drive(1'b1, vq[6].x, vq[6], 1'b0);
    drive(1'b1, vq[7].x, vq[7], 1'b0);
    @(negedge clk);
    rstn     = 1'b0;
    x_valid  = 1'b0;
    last_y   = 32'h0;
    last_yt  = 32'h0;
    last_ovf = 1'b0;
    last_unf = 1'b0;
    @(negedge clk);
    check("midrst_y", y, 32'h0);
    check("midrst_valid", 32'(y_valid), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_unf", 32'(unf), 32'd0);
    rstn = 1'b1;
    send(1);
    repeat (6) idle();

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fsquare.md
Name: fsquare

Overview:
- Pipelined single-precision floating-point squaring unit, y = x*x.
- Forward counterpart of the sqrt unit in the FPU datapath.
- Accepts one operand per cycle with a valid strobe and returns the result a fixed 3 cycles later.
- Flags overflow/underflow for the FPU status logic.

Parameters:
- ROUND, 1: 1 = round-half-up on the first discarded mantissa bit; 0 = truncate.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- x  in  32  IEEE-754 single operand
- x_valid  in  1  x is valid this cycle
- y  out  32  result x*x
- y_valid  out  1  y/ovf/unf valid this cycle
- ovf  out  1  result overflowed to +inf
- unf  out  1  result underflowed to +0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rstn.
- Reset (rstn=0 at a rising edge):
  - all stage valid bits, y, y_valid, ovf and unf go to 0;
  - in-flight operands are discarded and never appear on y_valid.
- Latency and throughput:
  - operand sampled at edge N gives y_valid=1 after edge N+3;
  - full throughput, no stall or backpressure;
  - gaps in x_valid appear as identical gaps in y_valid.
- Output hold: y, ovf and unf update only when a valid result leaves stage 3, and otherwise hold the last result. y_valid is a 1-cycle pulse per result.
- Pipeline stages:
  - S1: register fields; classify zero/denormal (exp=0), inf (exp=255, frac=0) and NaN (exp=255, frac≠0).
  - S2: 24x24 unsigned multiply of {1,frac} by itself into a 48-bit product p; exponent sum es = 2*e - 127, 10-bit signed.
  - S3: normalize, round, check range, register outputs.
- Sign: always 0.
- Normalize:
  - if p[47]=1, mantissa = p[46:24], guard = p[23], es += 1;
  - otherwise mantissa = p[45:23], guard = p[22].
- Round (ROUND=1):
  - add guard to the mantissa;
  - on carry out, mantissa = 0 and es += 1.
- Specials, which take priority over the range check:
  - zero/denormal input: y=0x00000000, ovf=0, unf=0 (denormals flush to zero);
  - inf input: y=0x7F800000, ovf=0;
  - NaN input: y=0x7FC00000, ovf=0, unf=0.
- Range check:
  - es ≥ 255: y=0x7F800000, ovf=1;
  - es ≤ 0: y=0x00000000, unf=1;
  - otherwise y = {0, es[7:0], mantissa} with ovf=unf=0.
- Flags: ovf and unf are never 1 at the same time.
- Reset during streaming: outputs are 0 in the cycle after reset. The first post-reset operand is sampled at the first edge with rstn=1 and x_valid=1.

Test Plan:
- Basic values, single operands with x_valid pulses:
  - 0x40400000 (3.0) -> y=0x41100000, ovf=unf=0, y_valid exactly 3 edges later;
  - 0x3FC00000 -> 0x40100000;
  - 0xC0000000 -> 0x40800000.
- Rounding:
  - 0x3F800001 -> 0x3F800002;
  - 0x5F7FFFFF -> 0x7F7FFFFE, no ovf;
  - with ROUND=0, 0x3F800001 -> 0x3F800002 (truncated p[45:23]).
- Range limits:
  - 0x5F800000 (2^64) -> 0x7F800000, ovf=1;
  - 0x60AD78EC -> 0x7F800000, ovf=1;
  - 0x1E3CE508 (≈1e-20) -> 0x00000000, unf=1.
- Specials:
  - 0x00000000 -> 0;
  - 0x00400000 (denormal) -> 0, unf=0;
  - 0xFF800000 -> 0x7F800000, ovf=0;
  - 0x7FA00000 -> 0x7FC00000.
- Streaming:
  - 10 back-to-back operands, then a pattern 1,0,1,1,0 on x_valid;
  - results must arrive in order with the identical valid pattern delayed 3 cycles;
  - y must hold during gaps.
- Reset mid-flight:
  - rstn=0 for one edge while 3 operands are in the pipe;
  - no y_valid for them; y=0, ovf=unf=0 next cycle;
  - the next operand returns correctly after 3 edges.
